key_trig: RTL and testbench
===========================

KEY_TRIG -- requirements
Module: key_trig

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter DEB_CMAX, default 20 ms in clock cycles via the shared cycle-count macro, meaning stable cycles needed to accept a level change.
REQ-003 SHALL have parameter REP_DLY_CMAX, default 600 ms in cycles, meaning the hold time before the first auto-repeat.
REQ-004 SHALL have parameter REP_PER_CMAX, default 150 ms in cycles, meaning the auto-repeat period.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port btn_mod_n, btn_run_n, btn_wat_n, input, 1 each, raw asynchronous buttons, low = pressed.
REQ-008 SHALL have port tr_mod, tr_run, tr_wat, output, 1 each, single-cycle trigger pulses to the washer controller.
REQ-009 SHALL have port held, output, 3, debounced pressed level {wat,run,mod}.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer; the flops are set to the released level on reset.
REQ-011 SHALL run each channel's FSM with states LOCK, IDLE, PDEB, HELD, RDEB and a per-channel counter sized by $clog2 of the largest parameter.
REQ-012 SHALL in LOCK go to IDLE after DEB_CMAX consecutive released samples; a pressed sample clears the counter.
REQ-013 SHALL in IDLE go to PDEB and clear the counter on a pressed sample.
REQ-014 SHALL in PDEB go to HELD and raise a raw pulse after DEB_CMAX consecutive pressed samples; a released sample returns the channel to IDLE with no pulse.
REQ-015 SHALL in HELD go to RDEB on a released sample.
REQ-016 SHALL in RDEB go to IDLE after DEB_CMAX consecutive released samples; a pressed sample returns the channel to HELD with no new pulse.
REQ-017 SHALL give a press-to-pulse latency of exactly 2 + DEB_CMAX cycles after the first pressed raw level that is then held.
REQ-018 SHALL drive held[i] = 1 in HELD and RDEB, and 0 otherwise.
REQ-019 SHALL register the tr_* outputs, so each pulse lasts exactly one cycle.
REQ-020 SHALL resolve same-cycle raw pulses by priority run > mod > wat; only the winner is output and the losers are dropped, not queued.
REQ-021 SHALL treat channels as independent; a press on one channel SHALL NOT disturb another channel's counter.

Reset
REQ-022 SHALL on rst set every channel to LOCK, clear all counters, and drive tr_*=0 and held=0 on the next edge.
REQ-023 SHALL NOT pulse for a button held across reset release until that button is released for DEB_CMAX cycles and pressed again.
REQ-024 SHALL on reset mid-debounce or mid-repeat discard all partial counts.

Configuration
REQ-025 SHALL compile in auto-repeat for the mod and wat channels only when KEY_REPEAT_EN is defined; run never repeats.
REQ-026 SHALL with KEY_REPEAT_EN: in HELD, raise a raw pulse REP_DLY_CMAX cycles after entry, then every REP_PER_CMAX cycles while still in HELD; RDEB freezes the repeat count, and a return to HELD resumes it.
REQ-027 SHALL without KEY_REPEAT_EN: produce exactly one pulse per accepted press, and remove the REP_* counters from the RTL; the REP_* parameters are kept but ignored.

Structure
REQ-028 SHALL place the channel state encoding (LOCK..RDEB) and the channel index constants MOD=0, RUN=1, WAT=2 in the shared package.
REQ-029 SHALL implement one channel (synchronizer, FSM, counter) as sub-module key_chan, instantiated three times; key_trig holds the priority arbiter and the output registers.

Verification (DEB_CMAX=4, REP_DLY_CMAX=10, REP_PER_CMAX=3)
REQ-030 SHALL check: btn_run_n low from cycle 10 after reset release -> tr_run=1 only at cycle 16, held[1]=1 from cycle 16.
REQ-031 SHALL check: btn_mod_n low 3 cycles then high -> no tr_mod pulse, held stays 0.
REQ-032 SHALL check: btn_run_n and btn_wat_n go low in the same cycle -> tr_run pulses once, tr_wat never pulses for that press.
REQ-033 SHALL check: btn_wat_n held low through rst deassertion -> no pulse; after release of 4 or more cycles and a new press -> one tr_wat pulse 6 cycles later.
REQ-034 SHALL check with KEY_REPEAT_EN: btn_wat_n held 30 cycles -> tr_wat at cycles 6, 16, 19, 22, 25, 28 relative to press; without the macro -> only at cycle 6.
REQ-035 SHALL check: rst asserted 2 cycles after btn_mod_n falls -> no tr_mod pulse, all outputs 0 on the cycle after rst.

Source files
------------

// File: rtl/key_trig_pkg.sv
// Shared definitions for the key_trig button front end: channel states,
// channel indices and the ms-to-cycles macro used for parameter defaults.
`ifndef KEY_MS2CYC
`define KEY_MS2CYC(ms) ((ms) * (key_trig_pkg::CLK_HZ / 1000))
`endif

package key_trig_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    ST_LOCK,
    ST_IDLE,
    ST_PDEB,
    ST_HELD,
    ST_RDEB
  } chan_st_e;

  localparam int unsigned MOD = 0;
  localparam int unsigned RUN = 1;
  localparam int unsigned WAT = 2;
  localparam int unsigned NCH = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter.
// Auto-repeat logic exists only when KEY_REPEAT_EN is defined.
module key_chan
  import key_trig_pkg::*;
#(
  parameter int unsigned DEB_CMAX     = 4,
`ifdef KEY_REPEAT_EN
  parameter int unsigned REP_DLY_CMAX = 10,
  parameter int unsigned REP_PER_CMAX = 3,
  parameter bit          REP_EN       = 1'b0,
`endif
  parameter int unsigned CW           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_pulse,
  output logic o_held
);

  logic          r_s1, r_s2;
  chan_st_e      r_st, w_st_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_press, w_deb_done, w_deb_pulse;

  assign w_press    = ~r_s2;
  assign w_deb_done = (r_cnt == CW'(DEB_CMAX - 1));
  assign o_held     = (r_st == ST_HELD) || (r_st == ST_RDEB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_st  <= ST_LOCK;
      r_cnt <= '0;
    end else begin
      r_s1  <= i_btn_n;
      r_s2  <= r_s1;
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_cnt_nxt   = r_cnt;
    w_deb_pulse = 1'b0;
    case (r_st)
      ST_LOCK: begin
        if (w_press) begin
          w_cnt_nxt = '0;
        end else if (w_deb_done) begin
          w_st_nxt  = ST_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_IDLE: begin
        if (w_press) begin
          w_st_nxt  = ST_PDEB;
          w_cnt_nxt = '0;
        end
      end
      ST_PDEB: begin
        if (!w_press) begin
          w_st_nxt  = ST_IDLE;
          w_cnt_nxt = '0;
        end else if (w_deb_done) begin
          w_st_nxt    = ST_HELD;
          w_cnt_nxt   = '0;
          w_deb_pulse = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_HELD: begin
        if (!w_press) begin
          w_st_nxt  = ST_RDEB;
          w_cnt_nxt = '0;
        end
      end
      ST_RDEB: begin
        if (w_press) begin
          w_st_nxt  = ST_HELD;
          w_cnt_nxt = '0;
        end else if (w_deb_done) begin
          w_st_nxt  = ST_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_st_nxt  = ST_LOCK;
        w_cnt_nxt = '0;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  // Separate repeat counter so RDEB debounce can run while the repeat phase is frozen.
  logic [CW-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic          r_rep_per, w_rep_per_nxt;
  logic          w_rep_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt <= '0;
      r_rep_per <= 1'b0;
    end else begin
      r_rep_cnt <= w_rep_cnt_nxt;
      r_rep_per <= w_rep_per_nxt;
    end
  end

  always_comb begin
    w_rep_cnt_nxt = r_rep_cnt;
    w_rep_per_nxt = r_rep_per;
    w_rep_pulse   = 1'b0;
    if (w_deb_pulse) begin
      w_rep_cnt_nxt = '0;
      w_rep_per_nxt = 1'b0;
    end else if (REP_EN && (r_st == ST_HELD) && w_press) begin
      if (r_rep_cnt == (r_rep_per ? CW'(REP_PER_CMAX - 1) : CW'(REP_DLY_CMAX - 1))) begin
        w_rep_pulse   = 1'b1;
        w_rep_cnt_nxt = '0;
        w_rep_per_nxt = 1'b1;
      end else begin
        w_rep_cnt_nxt = r_rep_cnt + CW'(1);
      end
    end
  end

  assign o_pulse = w_deb_pulse | w_rep_pulse;
`else
  assign o_pulse = w_deb_pulse;
`endif

endmodule

// File: rtl/key_trig.sv
// Three debounced button channels with a run > mod > wat pulse arbiter.
// Define KEY_REPEAT_EN to enable auto-repeat on the mod and wat channels.
module key_trig
  import key_trig_pkg::*;
#(
  parameter int unsigned DEB_CMAX     = `KEY_MS2CYC(20),
  parameter int unsigned REP_DLY_CMAX = `KEY_MS2CYC(600),
  parameter int unsigned REP_PER_CMAX = `KEY_MS2CYC(150)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mod_n,
  input  logic       btn_run_n,
  input  logic       btn_wat_n,
  output logic       tr_mod,
  output logic       tr_run,
  output logic       tr_wat,
  output logic [2:0] held
);

  localparam int unsigned CNT_MAX = max3(DEB_CMAX, REP_DLY_CMAX, REP_PER_CMAX);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [NCH-1:0] w_btn_n, w_pulse, w_held, w_tr_nxt;
  logic [NCH-1:0] r_tr;

  assign w_btn_n = {btn_wat_n, btn_run_n, btn_mod_n};

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    key_chan #(
      .DEB_CMAX    (DEB_CMAX),
`ifdef KEY_REPEAT_EN
      .REP_DLY_CMAX(REP_DLY_CMAX),
      .REP_PER_CMAX(REP_PER_CMAX),
      .REP_EN      (g != RUN),
`endif
      .CW          (CW)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_btn_n(w_btn_n[g]),
      .o_pulse(w_pulse[g]),
      .o_held (w_held[g])
    );
  end

  // Losing same-cycle pulses are dropped, not deferred.
  always_comb begin
    w_tr_nxt = '0;
    if (w_pulse[RUN])      w_tr_nxt[RUN] = 1'b1;
    else if (w_pulse[MOD]) w_tr_nxt[MOD] = 1'b1;
    else if (w_pulse[WAT]) w_tr_nxt[WAT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_tr <= '0;
    else     r_tr <= w_tr_nxt;
  end

  assign tr_mod = r_tr[MOD];
  assign tr_run = r_tr[RUN];
  assign tr_wat = r_tr[WAT];
  assign held   = w_held;

endmodule

// File: tb/tb_key_trig.sv
// Directed bench for key_trig with DEB_CMAX=4, REP_DLY_CMAX=10, REP_PER_CMAX=3.
// Vector/output bit order everywhere is {wat,run,mod}.
module tb_key_trig;

  logic       clk;
  logic       rst;
  logic [2:0] btn_n;
  logic       tr_mod, tr_run, tr_wat;
  logic [2:0] held;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  key_trig #(
    .DEB_CMAX    (4),
    .REP_DLY_CMAX(10),
    .REP_PER_CMAX(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mod_n(btn_n[0]),
    .btn_run_n(btn_n[1]),
    .btn_wat_n(btn_n[2]),
    .tr_mod   (tr_mod),
    .tr_run   (tr_run),
    .tr_wat   (tr_wat),
    .held     (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  btn_n;
    int unsigned n;
    logic [2:0]  tr;
    logic [2:0]  held;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [2:0] b, input int unsigned n,
                              input logic [2:0] t, input logic [2:0] h);
    vec_t v;
    v.rst = r; v.btn_n = b; v.n = n; v.tr = t; v.held = h;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [2:0] exp_tr, input logic [2:0] exp_held);
    logic [2:0] got_tr;
    got_tr = {tr_wat, tr_run, tr_mod};
    n_chk++;
    if (got_tr !== exp_tr) begin
      n_err++;
      $display("FAIL %s cyc=%0d tr got=%b exp=%b", nm, cyc, got_tr, exp_tr);
    end
    n_chk++;
    if (held !== exp_held) begin
      n_err++;
      $display("FAIL %s cyc=%0d held got=%b exp=%b", nm, cyc, held, exp_held);
    end
  endtask

  initial begin
    rst   = 1'b1;
    btn_n = 3'b111;

    // reset, run press at cycle 10 -> pulse at 16, release
    tbl.push_back(mk(1'b1, 3'b111, 3, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b111, 9, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b101, 6, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b101, 1, 3'b010, 3'b010));
    tbl.push_back(mk(1'b0, 3'b101, 6, 3'b000, 3'b010));
    tbl.push_back(mk(1'b0, 3'b111, 6, 3'b000, 3'b010));
    tbl.push_back(mk(1'b0, 3'b111, 4, 3'b000, 3'b000));
    // mod glitch of 3 cycles: rejected
    tbl.push_back(mk(1'b0, 3'b110, 3, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b111, 10, 3'b000, 3'b000));
    // shortest accepted mod press (5 cycles)
    tbl.push_back(mk(1'b0, 3'b110, 5, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b111, 1, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b111, 1, 3'b001, 3'b001));
    tbl.push_back(mk(1'b0, 3'b111, 4, 3'b000, 3'b001));
    tbl.push_back(mk(1'b0, 3'b111, 4, 3'b000, 3'b000));
    // run and wat together: run wins, wat dropped
    tbl.push_back(mk(1'b0, 3'b001, 6, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b001, 1, 3'b010, 3'b110));
    tbl.push_back(mk(1'b0, 3'b001, 5, 3'b000, 3'b110));
    tbl.push_back(mk(1'b0, 3'b111, 6, 3'b000, 3'b110));
    tbl.push_back(mk(1'b0, 3'b111, 4, 3'b000, 3'b000));
    // mod then run two cycles later: independent channels
    tbl.push_back(mk(1'b0, 3'b110, 2, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b100, 4, 3'b000, 3'b000));
    tbl.push_back(mk(1'b0, 3'b100, 1, 3'b001, 3'b001));
    tbl.push_back(mk(1'b0, 3'b100, 1, 3'b000, 3'b001));
    tbl.push_back(mk(1'b0, 3'b100, 1, 3'b010, 3'b011));
    tbl.push_back(mk(1'b0, 3'b100, 3, 3'b000, 3'b011));
    tbl.push_back(mk(1'b0, 3'b111, 6, 3'b000, 3'b011));
    tbl.push_back(mk(1'b0, 3'b111, 4, 3'b000, 3'b000));

    foreach (tbl[i]) begin
      for (int unsigned j = 0; j < tbl[i].n; j++) begin
        rst   = tbl[i].rst;
        btn_n = tbl[i].btn_n;
        step();
        chk($sformatf("tbl%0d", i), tbl[i].tr, tbl[i].held);
      end
    end

    // wat held across reset release: locked until released and pressed again
    rst = 1'b1; btn_n = 3'b011;
    for (int k = 0; k < 3; k++) begin step(); chk("lock_rst", 3'b000, 3'b000); end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin step(); chk("lock_hold", 3'b000, 3'b000); end
    btn_n = 3'b111;
    for (int k = 0; k < 6; k++) begin step(); chk("lock_rel", 3'b000, 3'b000); end
    btn_n = 3'b011;
    for (int k = 0; k <= 10; k++) begin
      step();
      chk("lock_press", (k == 6) ? 3'b100 : 3'b000, (k >= 6) ? 3'b100 : 3'b000);
    end
    btn_n = 3'b111;
    for (int k = 0; k < 10; k++) step();
    chk("lock_idle", 3'b000, 3'b000);

    // wat held 30 cycles: repeat pattern depends on build
    btn_n = 3'b011;
    for (int k = 0; k < 30; k++) begin
      step();
      chk("rep", ((k == 6) || (REP && k >= 16 && ((k - 16) % 3) == 0)) ? 3'b100 : 3'b000,
          (k >= 6) ? 3'b100 : 3'b000);
    end
    btn_n = 3'b111;
    for (int k = 0; k < 12; k++) step();
    chk("rep_idle", 3'b000, 3'b000);

    // reset two cycles into a mod press
    btn_n = 3'b110;
    for (int k = 0; k < 2; k++) begin step(); chk("rstdeb_pre", 3'b000, 3'b000); end
    rst = 1'b1;
    step(); chk("rstdeb_rst", 3'b000, 3'b000);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin step(); chk("rstdeb_hold", 3'b000, 3'b000); end
    btn_n = 3'b111;
    for (int k = 0; k < 8; k++) begin step(); chk("rstdeb_rel", 3'b000, 3'b000); end

    // reset while run is in HELD
    btn_n = 3'b101;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rsthld_pre", (k == 6) ? 3'b010 : 3'b000, (k >= 6) ? 3'b010 : 3'b000);
    end
    rst = 1'b1;
    step(); chk("rsthld_rst", 3'b000, 3'b000);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin step(); chk("rsthld_hold", 3'b000, 3'b000); end
    btn_n = 3'b111;
    for (int k = 0; k < 8; k++) begin step(); chk("rsthld_rel", 3'b000, 3'b000); end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
